// File: rtl/intr_pkg.sv
// rtl/intr_pkg.sv - shared state encoding, default sizing and vector math for the interrupt controller
package intr_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        TAKE    = 2'd1,
        SERVICE = 2'd2
    } intr_state_e;

    localparam int DEF_NCH    = 4;
    localparam int DEF_AW     = 10;
    localparam int DEF_BASE   = 824;
    localparam int DEF_STRIDE = 50;

    // Callers truncate to their address width; the low bits match an AW+8 bit computation.
    function automatic int unsigned vec_addr(input int unsigned base,
                                             input int unsigned stride,
                                             input int unsigned id);
        return base + id * stride;
    endfunction

endpackage

// File: rtl/prio_enc.sv
// rtl/prio_enc.sv - combinational fixed-priority encoder, lowest set index wins
module prio_enc #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    output logic          valid,
    output logic [IW-1:0] idx
);

    // Scan downward so the last assignment belongs to the lowest set bit.
    always_comb begin
        valid = |req;
        idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = IW'(i);
            end
        end
    end

endmodule

// File: rtl/intr_ctrl.sv
// rtl/intr_ctrl.sv - vectored interrupt controller top; define INTR_EDGE_EN for edge-triggered requests
module intr_ctrl
    import intr_pkg::*;
#(
    parameter int            NCH      = DEF_NCH,
    parameter int            AW       = DEF_AW,
    parameter int            BASE     = DEF_BASE,
    parameter int            STRIDE   = DEF_STRIDE,
    parameter logic [NCH-1:0] MASK_RST = '1,
    localparam int           IDW      = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [NCH-1:0] irq,
    input  logic           fin,
    input  logic           mask_we,
    input  logic [NCH-1:0] mask_wd,
    output logic           s_interrup,
    output logic [AW-1:0]  dir,
    output logic           busy,
    output logic [IDW-1:0] cur_id,
    output logic [NCH-1:0] pending,
    output logic [NCH-1:0] mask
);

    generate
        if (NCH < 1 || NCH > 16) begin : g_bad_nch
            $error("intr_ctrl: NCH must be in 1..16");
        end
        if (longint'(BASE) + longint'(NCH - 1) * longint'(STRIDE) >= (longint'(1) << AW)) begin : g_bad_vec
            $error("intr_ctrl: highest vector does not fit in AW bits");
        end
    endgenerate

    intr_state_e    state, state_nxt;
    logic [NCH-1:0] set_ev;
    logic [NCH-1:0] elig;
    logic [NCH-1:0] take_clr;
    logic           win_valid;
    logic [IDW-1:0] win_id;

`ifdef INTR_EDGE_EN
    logic [NCH-1:0] irq_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            irq_q <= '0;
        end else begin
            irq_q <= irq;
        end
    end

    assign set_ev = irq & ~irq_q;
`else
    assign set_ev = irq;
`endif

    assign elig = pending & mask;

    prio_enc #(.N(NCH), .IW(IDW)) u_prio (
        .req   (elig),
        .valid (win_valid),
        .idx   (win_id)
    );

    always_comb begin
        take_clr = '0;
        if (state == IDLE && win_valid) begin
            take_clr[win_id] = 1'b1;
        end
    end

    // A new request landing on the bit being taken keeps it pending.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending <= '0;
            mask    <= MASK_RST;
        end else begin
            pending <= (pending & ~take_clr) | set_ev;
            if (mask_we) begin
                mask <= mask_wd;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (win_valid) state_nxt = TAKE;
            TAKE:    state_nxt = SERVICE;
            SERVICE: if (fin) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dir    <= '0;
            cur_id <= '0;
        end else if (state == IDLE) begin
            if (win_valid) begin
                cur_id <= win_id;
                dir    <= AW'(vec_addr(BASE, STRIDE, 32'(win_id)));
            end else begin
                dir <= '0;
            end
        end else if (state == SERVICE && fin) begin
            dir <= '0;
        end
    end

    assign s_interrup = (state == TAKE);
    assign busy       = (state == TAKE) || (state == SERVICE);

endmodule

// File: tb/tb_intr_ctrl.sv
// tb/tb_intr_ctrl.sv - directed vector bench for intr_ctrl
module tb_intr_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] irq;
    logic       fin;
    logic       mask_we;
    logic [3:0] mask_wd;
    logic       s_interrup;
    logic [9:0] dir;
    logic       busy;
    logic [1:0] cur_id;
    logic [3:0] pending;
    logic [3:0] mask;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    intr_ctrl #(.NCH(4), .AW(10), .BASE(824), .STRIDE(50)) dut (
        .clk        (clk),
        .reset      (reset),
        .irq        (irq),
        .fin        (fin),
        .mask_we    (mask_we),
        .mask_wd    (mask_wd),
        .s_interrup (s_interrup),
        .dir        (dir),
        .busy       (busy),
        .cur_id     (cur_id),
        .pending    (pending),
        .mask       (mask)
    );

    typedef struct {
        logic       s;
        logic       b;
        logic [9:0] dir;
        logic [1:0] cur;
        logic [3:0] pend;
        logic [3:0] msk;
        logic [3:0] irq;
        logic       fin;
        logic       mwe;
        logic [3:0] mwd;
    } vec_t;

    vec_t tv[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic add(input logic s, input logic b, input logic [9:0] d, input logic [1:0] c,
                       input logic [3:0] p, input logic [3:0] m, input logic [3:0] i,
                       input logic f, input logic we, input logic [3:0] wd);
        vec_t v;
        v.s = s; v.b = b; v.dir = d; v.cur = c; v.pend = p; v.msk = m;
        v.irq = i; v.fin = f; v.mwe = we; v.mwd = wd;
        tv.push_back(v);
    endtask

    // Observe outputs at the falling edge, then drive fin from them so every SERVICE ends at once.
    task automatic run_serv(input int n, input logic [3:0] lvl, output int takes);
        takes = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (s_interrup) begin
                takes++;
                chk("hold_dir", 32'(dir), 32'd974);
            end
            fin = busy && !s_interrup;
            irq = lvl;
        end
        fin = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int takes;
        int exp_win, exp_drain, exp_rearm;

        // Row fields: observed s,busy,dir,cur,pend,mask | then driven irq,fin,mask_we,mask_wd
        add(0,0,  0,0,4'h0,4'hF, 4'h4,0,0,4'h0);
        add(0,0,  0,0,4'h4,4'hF, 4'h0,0,0,4'h0);
        add(1,1,924,2,4'h0,4'hF, 4'h0,0,0,4'h0);
        add(0,1,924,2,4'h0,4'hF, 4'h0,1,0,4'h0);
        add(0,0,  0,2,4'h0,4'hF, 4'hA,0,0,4'h0);
        add(0,0,  0,2,4'hA,4'hF, 4'h0,0,0,4'h0);
        add(1,1,874,1,4'h8,4'hF, 4'h0,1,0,4'h0);
        add(0,1,874,1,4'h8,4'hF, 4'h0,0,0,4'h0);
        add(0,1,874,1,4'h8,4'hF, 4'h0,1,0,4'h0);
        add(0,0,  0,1,4'h8,4'hF, 4'h0,0,0,4'h0);
        add(1,1,974,3,4'h0,4'hF, 4'h0,0,0,4'h0);
        add(0,1,974,3,4'h0,4'hF, 4'h0,1,0,4'h0);
        add(0,0,  0,3,4'h0,4'hF, 4'h4,0,0,4'h0);
        add(0,0,  0,3,4'h4,4'hF, 4'h0,0,0,4'h0);
        add(1,1,924,2,4'h0,4'hF, 4'h0,0,0,4'h0);
        add(0,1,924,2,4'h0,4'hF, 4'h1,0,0,4'h0);
        add(0,1,924,2,4'h1,4'hF, 4'h0,0,0,4'h0);
        add(0,1,924,2,4'h1,4'hF, 4'h0,1,0,4'h0);
        add(0,0,  0,2,4'h1,4'hF, 4'h0,0,0,4'h0);
        add(1,1,824,0,4'h0,4'hF, 4'h0,0,0,4'h0);
        add(0,1,824,0,4'h0,4'hF, 4'h0,1,0,4'h0);
        add(0,0,  0,0,4'h0,4'hF, 4'h0,0,1,4'hE);
        add(0,0,  0,0,4'h0,4'hE, 4'h1,0,0,4'h0);
        add(0,0,  0,0,4'h1,4'hE, 4'h0,0,0,4'h0);
        add(0,0,  0,0,4'h1,4'hE, 4'h0,0,1,4'hF);
        add(0,0,  0,0,4'h1,4'hF, 4'h0,0,0,4'h0);
        add(1,1,824,0,4'h0,4'hF, 4'h0,0,1,4'hE);
        add(0,1,824,0,4'h0,4'hE, 4'h0,0,1,4'hF);
        add(0,1,824,0,4'h0,4'hF, 4'h0,1,0,4'h0);
        add(0,0,  0,0,4'h0,4'hF, 4'h0,1,0,4'h0);
        add(0,0,  0,0,4'h0,4'hF, 4'h0,0,0,4'h0);

        reset = 1'b1; irq = '0; fin = 1'b0; mask_we = 1'b0; mask_wd = '0;
        repeat (2) @(negedge clk);
        chk("rst_s",    32'(s_interrup), 32'd0);
        chk("rst_busy", 32'(busy),       32'd0);
        chk("rst_dir",  32'(dir),        32'd0);
        chk("rst_cur",  32'(cur_id),     32'd0);
        chk("rst_pend", 32'(pending),    32'd0);
        chk("rst_mask", 32'(mask),       32'hF);
        reset = 1'b0;

        for (int r = 0; r < tv.size(); r++) begin
            @(negedge clk);
            chk($sformatf("row%0d_s", r),    32'(s_interrup), 32'(tv[r].s));
            chk($sformatf("row%0d_busy", r), 32'(busy),       32'(tv[r].b));
            chk($sformatf("row%0d_dir", r),  32'(dir),        32'(tv[r].dir));
            chk($sformatf("row%0d_cur", r),  32'(cur_id),     32'(tv[r].cur));
            chk($sformatf("row%0d_pend", r), 32'(pending),    32'(tv[r].pend));
            chk($sformatf("row%0d_mask", r), 32'(mask),       32'(tv[r].msk));
            irq = tv[r].irq; fin = tv[r].fin; mask_we = tv[r].mwe; mask_wd = tv[r].mwd;
        end

        // Reset in the middle of a service with a pending request and a modified mask.
        @(negedge clk); irq = 4'h2; fin = 1'b0; mask_we = 1'b0;
        @(negedge clk); irq = 4'h0;
        @(negedge clk); chk("mid_take", 32'(s_interrup), 32'd1);
        @(negedge clk); irq = 4'h4; mask_we = 1'b1; mask_wd = 4'h3;
        @(negedge clk);
        irq = 4'h0; mask_we = 1'b0;
        chk("mid_busy", 32'(busy),    32'd1);
        chk("mid_pend", 32'(pending), 32'h4);
        chk("mid_mask", 32'(mask),    32'h3);
        chk("mid_dir",  32'(dir),     32'd874);
        reset = 1'b1;
        @(negedge clk);
        chk("mrst_busy", 32'(busy),       32'd0);
        chk("mrst_s",    32'(s_interrup), 32'd0);
        chk("mrst_pend", 32'(pending),    32'd0);
        chk("mrst_mask", 32'(mask),       32'hF);
        chk("mrst_dir",  32'(dir),        32'd0);
        chk("mrst_cur",  32'(cur_id),     32'd0);
        reset = 1'b0; fin = 1'b1;
        @(negedge clk);
        fin = 1'b0;
        chk("pfin_busy", 32'(busy),       32'd0);
        chk("pfin_s",    32'(s_interrup), 32'd0);
        chk("pfin_dir",  32'(dir),        32'd0);
        @(negedge clk);
        chk("pfin2_busy", 32'(busy),       32'd0);
        chk("pfin2_s",    32'(s_interrup), 32'd0);

        // Held request on channel 3.
`ifdef INTR_EDGE_EN
        exp_win = 1; exp_drain = 0; exp_rearm = 1;
`else
        exp_win = 4; exp_drain = 1; exp_rearm = 2;
`endif
        run_serv(12, 4'h8, takes);
        chk("hold_takes", 32'(takes), 32'(exp_win));
        run_serv(8, 4'h0, takes);
        chk("drain_takes", 32'(takes), 32'(exp_drain));
        @(negedge clk);
        chk("drain_busy", 32'(busy),    32'd0);
        chk("drain_pend", 32'(pending), 32'd0);
        run_serv(6, 4'h8, takes);
        chk("rearm_takes", 32'(takes), 32'(exp_rearm));
        run_serv(8, 4'h0, takes);
        @(negedge clk);
        chk("end_busy", 32'(busy),    32'd0);
        chk("end_pend", 32'(pending), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
